// File: rtl/adder_dly_pipe.sv
// -----------------------------------------------------------------------------
// adder_dly_pipe
//
// Purpose:
//   Clocked, synthesizable stand-in for a '#'-delayed adder. Each accepted
//   sample computes {co, sum} = a + b + ci at WIDTH+1 bits. The result is
//   presented exactly LAT clock cycles after the sample cycle. INERTIAL picks
//   the delay discipline:
//     0 = transport: every accepted sample comes out, one per cycle if needed.
//     1 = inertial : a sample comes out only if no newer sample replaces it
//                    before its delay runs out. Replaced samples are counted.
//
// Parameters:
//   WIDTH     operand / sum width (1..32)
//   LAT       sample-to-output delay in cycles (1..64)
//   INERTIAL  0 = transport, 1 = inertial
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_vld    a, b, ci form a sample this cycle
//   a, b      operands (WIDTH bits)
//   ci        carry in
//   flush     synchronous discard of every in-flight / pending sample
//   out_vld   one-cycle pulse, a new result is on co/sum
//   sum       low WIDTH bits of the result, held between pulses
//   co        bit WIDTH of the result, held between pulses
//   drop_cnt  saturating count of samples replaced in inertial mode
// -----------------------------------------------------------------------------
module adder_dly_pipe #(
    parameter int WIDTH    = 4,
    parameter int LAT      = 12,
    parameter int INERTIAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             flush,
    output logic             out_vld,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic [7:0]       drop_cnt
);

    localparam int RW = WIDTH + 1;

    logic [RW-1:0] newRes;
    logic          accept;

    // Result and valid handed to the output registers on the coming edge.
    logic          launchVld;
    logic [RW-1:0] launchRes;
    logic          dropInc;

    logic          outVld_q;
    logic          outVld_d;
    logic [RW-1:0] outRes_q;
    logic [RW-1:0] outRes_d;
    logic [7:0]    dropCnt_q;
    logic [7:0]    dropCnt_d;

    // Full WIDTH+1 bit sum, so the carry out is never lost before the split.
    assign newRes = {1'b0, a} + {1'b0, b} + RW'(ci);

    // A sample presented together with flush is ignored.
    assign accept = in_vld & ~flush;

    generate
        if (LAT == 1) begin : gDirect
            // One cycle of delay is just the output register itself. An
            // inertial sample can never be replaced within zero waiting
            // cycles, so both disciplines reduce to this path.
            assign launchVld = accept;
            assign launchRes = newRes;
            assign dropInc   = 1'b0;
        end else if (INERTIAL != 0) begin : gInertial
            localparam int TW = 7;

            logic          pend_q;
            logic          pend_d;
            logic [RW-1:0] pendRes_q;
            logic [RW-1:0] pendRes_d;
            logic [TW-1:0] timer_q;
            logic [TW-1:0] timer_d;
            logic          expire;

            // The timer holds the number of edges still to pass before the
            // edge that launches the pending result. Loading LAT-1 on the
            // accepting edge makes that launch edge the end of cycle
            // c+LAT-1, so the pulse is seen in cycle c+LAT.
            assign expire = pend_q && (timer_q == TW'(1));

            // Pending-slot next state. A sample arriving while pending
            // (including the launch cycle itself) replaces the stored result
            // and suppresses its launch. A sample arriving in the cycle the
            // pulse is visible finds the slot already idle and is no drop.
            always_comb begin
                pend_d    = pend_q;
                pendRes_d = pendRes_q;
                timer_d   = timer_q;
                launchVld = 1'b0;
                launchRes = pendRes_q;
                dropInc   = 1'b0;
                if (flush) begin
                    pend_d  = 1'b0;
                    timer_d = '0;
                end else if (in_vld) begin
                    pend_d    = 1'b1;
                    pendRes_d = newRes;
                    timer_d   = TW'(LAT - 1);
                    dropInc   = pend_q;
                end else if (pend_q) begin
                    if (expire) begin
                        launchVld = 1'b1;
                        pend_d    = 1'b0;
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end

            // Pending slot and its down-counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_q    <= 1'b0;
                    pendRes_q <= '0;
                    timer_q   <= '0;
                end else begin
                    pend_q    <= pend_d;
                    pendRes_q <= pendRes_d;
                    timer_q   <= timer_d;
                end
            end
        end else begin : gTransport
            // LAT-1 stages ahead of the output register; together with the
            // output register the line is exactly LAT deep.
            localparam int PD = LAT - 1;

            assign dropInc = 1'b0;

            for (genvar s = 0; s < PD; s++) begin : gStage
                logic          vld_q;
                logic [RW-1:0] res_q;
                logic          srcVld;
                logic [RW-1:0] srcRes;

                if (s == 0) begin : gHead
                    assign srcVld = accept;
                    assign srcRes = newRes;
                end else begin : gBody
                    assign srcVld = gStage[s-1].vld_q & ~flush;
                    assign srcRes = gStage[s-1].res_q;
                end

                // One stage of the shift line; flush empties every stage.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        vld_q <= 1'b0;
                        res_q <= '0;
                    end else begin
                        vld_q <= srcVld;
                        res_q <= srcRes;
                    end
                end
            end

            assign launchVld = gStage[PD-1].vld_q;
            assign launchRes = gStage[PD-1].res_q;
        end
    endgenerate

    // Output stage: the pulse lasts one cycle, the result is captured only
    // with a pulse so sum/co hold in between, and flush blocks any launch.
    always_comb begin
        outVld_d  = launchVld & ~flush;
        outRes_d  = outRes_q;
        dropCnt_d = dropCnt_q;
        if (launchVld && !flush) begin
            outRes_d = launchRes;
        end
        if (dropInc && (dropCnt_q != 8'hFF)) begin
            dropCnt_d = dropCnt_q + 8'd1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outVld_q  <= 1'b0;
            outRes_q  <= '0;
            dropCnt_q <= '0;
        end else begin
            outVld_q  <= outVld_d;
            outRes_q  <= outRes_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    assign out_vld  = outVld_q;
    assign sum      = outRes_q[WIDTH-1:0];
    assign co       = outRes_q[WIDTH];
    assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_adder_dly_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_dly_pipe
//
// Purpose:
//   Drives one transport and one inertial adder_dly_pipe (WIDTH=4, LAT=12)
//   from the same inputs and compares both against a cycle-indexed reference
//   model: a record of which cycles carried an accepted sample and its sum.
//   Transport expects a pulse LAT cycles after every live sample; inertial
//   expects it only when no newer sample came in between.
//
// Ports: none (self-contained bench).
// -----------------------------------------------------------------------------
module tb_adder_dly_pipe;

    localparam int WIDTH = 4;
    localparam int LAT   = 12;
    localparam int MAXC  = 4096;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             in_vld = 1'b0;
    logic [WIDTH-1:0] a      = '0;
    logic [WIDTH-1:0] b      = '0;
    logic             ci     = 1'b0;
    logic             flush  = 1'b0;

    logic             outVldT;
    logic [WIDTH-1:0] sumT;
    logic             coT;
    logic [7:0]       dropT;
    logic             outVldI;
    logic [WIDTH-1:0] sumI;
    logic             coI;
    logic [7:0]       dropI;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: accepted samples per cycle, last cycle whose
    // samples (and all earlier ones) were discarded by flush or reset.
    bit sVld [MAXC];
    int sRes [MAXC];
    int lastKill = -1;

    int expSumT  = 0;
    int expCoT   = 0;
    int expSumI  = 0;
    int expCoI   = 0;
    int expDropI = 0;

    adder_dly_pipe #(.WIDTH(WIDTH), .LAT(LAT), .INERTIAL(0)) dutT (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .flush    (flush),
        .out_vld  (outVldT),
        .sum      (sumT),
        .co       (coT),
        .drop_cnt (dropT)
    );

    adder_dly_pipe #(.WIDTH(WIDTH), .LAT(LAT), .INERTIAL(1)) dutI (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .flush    (flush),
        .out_vld  (outVldI),
        .sum      (sumI),
        .co       (coI),
        .drop_cnt (dropI)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Inertial view: is some live sample still waiting at cycle c?
    function automatic bit inertialPending(input int c);
        bit p = 1'b0;
        for (int k = c - LAT + 1; k < c; k++) begin
            if (k >= 0 && k > lastKill && sVld[k]) p = 1'b1;
        end
        return p;
    endfunction

    // Compare both DUTs with the model for the current cycle.
    task automatic checkCycle();
        int s;
        bit eT;
        bit eI;
        s  = cyc - LAT;
        eT = (s >= 0) && (s > lastKill) && sVld[s];
        eI = eT;
        if (eI) begin
            for (int k = s + 1; k < cyc; k++) begin
                if (sVld[k]) eI = 1'b0;
            end
        end
        if (eT) begin
            expSumT = sRes[s] % 16;
            expCoT  = (sRes[s] / 16) % 2;
        end
        if (eI) begin
            expSumI = sRes[s] % 16;
            expCoI  = (sRes[s] / 16) % 2;
        end
        checkOutput("T.out_vld", 32'(outVldT), 32'(eT));
        checkOutput("T.sum", 32'(sumT), expSumT);
        checkOutput("T.co", 32'(coT), expCoT);
        checkOutput("T.drop_cnt", 32'(dropT), 0);
        checkOutput("I.out_vld", 32'(outVldI), 32'(eI));
        checkOutput("I.sum", 32'(sumI), expSumI);
        checkOutput("I.co", 32'(coI), expCoI);
        checkOutput("I.drop_cnt", 32'(dropI), expDropI);
    endtask

    // Drive one cycle of inputs, update the model, step a clock, check.
    task automatic applyStimulus(input bit v, input int av, input int bv, input int cv, input bit fl);
        int am;
        int bm;
        int cm;
        am = av % 16;
        bm = bv % 16;
        cm = cv % 2;
        a      = am[WIDTH-1:0];
        b      = bm[WIDTH-1:0];
        ci     = cm[0];
        in_vld = v;
        flush  = fl;
        if (v && !fl) begin
            if (inertialPending(cyc)) expDropI = (expDropI < 255) ? expDropI + 1 : 255;
            sVld[cyc] = 1'b1;
            sRes[cyc] = am + bm + cm;
        end
        if (fl) lastKill = cyc;
        @(posedge clk);
        #1;
        cyc++;
        checkCycle();
    endtask

    task automatic runIdle(input int n);
        repeat (n) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".T.out_vld"}, 32'(outVldT), 0);
        checkOutput({tag, ".T.sum"}, 32'(sumT), 0);
        checkOutput({tag, ".T.co"}, 32'(coT), 0);
        checkOutput({tag, ".T.drop_cnt"}, 32'(dropT), 0);
        checkOutput({tag, ".I.out_vld"}, 32'(outVldI), 0);
        checkOutput({tag, ".I.sum"}, 32'(sumI), 0);
        checkOutput({tag, ".I.co"}, 32'(coI), 0);
        checkOutput({tag, ".I.drop_cnt"}, 32'(dropI), 0);
    endtask

    // Asynchronous reset pulse in the middle of the current cycle; released
    // well before the next rising edge.
    task automatic pulseReset();
        #1;
        rst_n = 1'b0;
        #1;
        lastKill = cyc - 1;
        expSumT  = 0;
        expCoT   = 0;
        expSumI  = 0;
        expCoI   = 0;
        expDropI = 0;
        checkReset("midrst");
        #1;
        rst_n = 1'b1;
    endtask

    // Directed sequence following the test plan, plus a random phase.
    initial begin
        $display("[TB] start");
        #12;
        checkReset("rst");
        rst_n = 1'b1;

        // Single sample: 3+5+1 = 9 after LAT cycles in both modes.
        runIdle(10);
        applyStimulus(1'b1, 3, 5, 1, 1'b0);
        runIdle(20);

        // Max operands then a small one back-to-back: transport 31 then 1,
        // inertial only the second (first replaced, one drop).
        applyStimulus(1'b1, 15, 15, 1, 1'b0);
        applyStimulus(1'b1, 1, 0, 0, 1'b0);
        runIdle(20);

        // Inertial replacement six cycles later: only sum=4 comes out.
        applyStimulus(1'b1, 1, 1, 0, 1'b0);
        runIdle(5);
        applyStimulus(1'b1, 2, 2, 0, 1'b0);
        runIdle(20);

        // Second sample in the cycle the first result is visible: both out.
        applyStimulus(1'b1, 6, 7, 1, 1'b0);
        runIdle(LAT - 1);
        applyStimulus(1'b1, 9, 4, 0, 1'b0);
        runIdle(25);

        // 300 consecutive random samples: drop_cnt saturates at 255.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 1)), 1'b0);
        end
        runIdle(20);

        // Sparse random traffic with occasional flush.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                          ($urandom_range(0, 39) == 0));
        end
        runIdle(20);

        // Samples in flight, then asynchronous reset mid-cycle.
        applyStimulus(1'b1, 4, 4, 0, 1'b0);
        applyStimulus(1'b1, 5, 5, 1, 1'b0);
        applyStimulus(1'b1, 8, 9, 1, 1'b0);
        runIdle(3);
        pulseReset();
        applyStimulus(1'b1, 2, 3, 1, 1'b0);
        runIdle(20);

        // Three samples in flight, then flush together with in_vld.
        applyStimulus(1'b1, 10, 3, 0, 1'b0);
        applyStimulus(1'b1, 12, 7, 1, 1'b0);
        applyStimulus(1'b1, 1, 14, 1, 1'b0);
        runIdle(3);
        applyStimulus(1'b1, 7, 7, 1, 1'b1);
        runIdle(20);
        applyStimulus(1'b1, 11, 13, 0, 1'b0);
        runIdle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
